// File: rtl/pipe_skid_reg.sv
// Pipeline latch with valid/ready handshake, one-entry skid buffer and flush.
// in_ready is decoded from state only, so there is no comb path from out_ready.
module pipe_skid_reg #(
   parameter int unsigned      WIDTH   = 32,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             r,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             accept, send;

   assign out_valid = (state_q != StEmpty);
   assign in_ready  = (state_q != StFull);
   assign occupancy = state_q;
   assign out_data  = main_q;

   assign accept = in_valid && in_ready;
   assign send   = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         // Squash drops entries but leaves data registers untouched.
         state_d = StEmpty;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (accept) begin
                  state_d = StOne;
                  main_d  = in_data;
               end
            end
            StOne: begin
               if (accept && send) begin
                  main_d = in_data;
               end else if (accept) begin
                  state_d = StFull;
                  skid_d  = in_data;
               end else if (send) begin
                  state_d = StEmpty;
               end
            end
            StFull: begin
               if (send) begin
                  state_d = StOne;
                  main_d  = skid_q;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (r) begin
         state_q <= StEmpty;
         main_q  <= RST_VAL;
         skid_q  <= RST_VAL;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule
